bin_to_bcd_serial: RTL

Sequential double-dabble converter that turns an unsigned binary value into four packed BCD digits for the 4-digit seven-segment display path. It sits directly upstream of `seven_segment_driver`: its `bcd` output drives the driver's 16-bit `inbin` bus, so the display shows decimal rather than hex. A start/done handshake launches each conversion. The last result is held stable between conversions, so the multiplexed display never shows intermediate shift values.

---
 rtl/display_pkg.sv | 27 ++
 rtl/bin_to_bcd_serial_if.sv | 17 +
 rtl/bcd_add3.sv | 9 +
 rtl/bin_to_bcd_serial.sv | 92 +++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, FSM state type and digit helpers for the display path
package display_pkg;

  localparam int DIGITS  = 4;
  localparam int BCD_MAX = 9999;
  localparam int CNT_W   = $clog2(14) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // A digit stays lit once it or any more significant digit is nonzero; units is always lit.
  function automatic logic [DIGITS-1:0] lz_mask_of(input logic [4*DIGITS-1:0] v);
    logic [DIGITS-1:0] m;
    logic seen;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (v[4*i +: 4] != 4'd0);
      m[i] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial_if.sv
// rtl/bin_to_bcd_serial_if.sv - start/done handshake and result bundle of the converter
interface bin_to_bcd_serial_if #(
  parameter int BIN_W = 14
) ();

  logic [BIN_W-1:0] bin;
  logic             start;
  logic             busy;
  logic             done;
  logic [15:0]      bcd;
  logic [3:0]       lz_mask;
  logic             ovf;

  modport master (output bin, start, input busy, done, bcd, lz_mask, ovf);
  modport slave  (input bin, start, output busy, done, bcd, lz_mask, ovf);

endinterface

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - single-digit double-dabble adjust (add 3 when the digit is 5 or more)
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// rtl/bin_to_bcd_serial.sv - sequential double-dabble binary to 4-digit BCD with held result
module bin_to_bcd_serial
  import display_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input logic               clk,
  input logic               reset,
  bin_to_bcd_serial_if.slave bus
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   binreg;
  logic [15:0]        work;
  logic [15:0]        adj;
  logic [15:0]        work_nxt;
  logic [15:0]        result;
  logic               ovf_l;
  logic               last;
  logic [31:0]        bin_ext;
  logic [15:0]        bcd_r;
  logic [3:0]         lz_r;
  logic               ovf_r;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_add3 u_add3 (
      .din  (work[4*i +: 4]),
      .dout (adj[4*i +: 4])
    );
  end

  assign work_nxt = {adj[14:0], binreg[BIN_W-1]};
  assign last     = (cnt == CNT_W'(BIN_W - 1));
  assign bin_ext  = 32'(bus.bin);
  // The result register is written on the last shift edge so it is already valid while DONE is up.
  assign result   = ovf_l ? 16'h9999 : work_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      binreg <= '0;
      work   <= '0;
      ovf_l  <= 1'b0;
      bcd_r  <= 16'h0000;
      lz_r   <= 4'b0001;
      ovf_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            binreg <= bus.bin;
            work   <= '0;
            cnt    <= '0;
            ovf_l  <= (bin_ext > 32'(BCD_MAX));
          end
        end
        SHIFT: begin
          work   <= work_nxt;
          binreg <= binreg << 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            bcd_r <= result;
            lz_r  <= lz_mask_of(result);
            ovf_r <= ovf_l;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.bcd     = bcd_r;
  assign bus.lz_mask = lz_r;
  assign bus.ovf     = ovf_r;

endmodule
